id_fwd_stage: RTL and testbench

Parametrised instruction-decode stage for the SimpleCPU pipeline, sitting between IF and EX. It:

- captures the fetched PC and buffers the instruction word that returns from instruction SRAM one cycle later;
- resolves operands through a configurable number of forwarding ports;
- detects load-use hazards and inserts interlock bubbles;
- resolves branches and jumps at issue.

A valid/ready handshake replaces the global stall vector, so IF and EX see backpressure directly.

---
 rtl/id_fwd_stage_if.sv | 44 ++++
 rtl/id_fwd_stage.sv | 165 ++++++++++++++++
 tb/tb_id_fwd_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_fwd_stage_if.sv
// Bus bundle for the ID stage: fetch handshake, SRAM data, regfile port,
// forwarding sources, and the issue/redirect outputs.
interface id_fwd_stage_if #(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 32
);
  logic                   if_valid;
  logic [31:0]            if_pc;
  logic                   id_ready;
  logic [31:0]            inst_rdata;
  logic [4:0]             rf_raddr1;
  logic [4:0]             rf_raddr2;
  logic [31:0]            rf_rdata1;
  logic [31:0]            rf_rdata2;
  logic [NUM_FWD-1:0]     fwd_we;
  logic [NUM_FWD-1:0]     fwd_is_load;
  logic [NUM_FWD*5-1:0]   fwd_waddr;
  logic [NUM_FWD*32-1:0]  fwd_wdata;
  logic                   ex_ready;
  logic                   id_valid;
  logic [31:0]            id_pc;
  logic [31:0]            id_inst;
  logic [31:0]            id_src1;
  logic [31:0]            id_src2;
  logic                   br_taken;
  logic [31:0]            br_target;
  logic [CNT_W-1:0]       interlock_cnt;

  // Environment side (IF, SRAM, regfile, later stages)
  modport master (
    output if_valid, if_pc, inst_rdata, rf_rdata1, rf_rdata2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, ex_ready,
    input  id_ready, rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst,
           id_src1, id_src2, br_taken, br_target, interlock_cnt
  );

  // Decode stage side
  modport slave (
    input  if_valid, if_pc, inst_rdata, rf_rdata1, rf_rdata2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, ex_ready,
    output id_ready, rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst,
           id_src1, id_src2, br_taken, br_target, interlock_cnt
  );
endinterface

// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: PC capture, instruction buffering, operand
// forwarding, load-use interlock and branch resolution at issue.
// Build option: define ID_FWD_EN to compile in the forwarding mux; without it
// any pending write to a source register stalls the stage instead.
module id_fwd_stage #(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 32
) (
  input logic           clk,
  input logic           rst,
  id_fwd_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LIVE, HOLD} state_t;

  state_t             state;
  logic [31:0]        pc_r;
  logic [31:0]        hold_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [31:0]        cur_inst;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [5:0]         op;
  logic [NUM_FWD-1:0] stall_src;
  logic               load_use;
  logic               issue;
  logic               accept;
  logic [31:0]        src1;
  logic [31:0]        src2;
  logic [31:0]        pc4;
  logic               taken;
  logic [31:0]        target;

  // Any stalling source that targets a nonzero rs or rt blocks issue
  function automatic logic hazard(input logic [4:0] a, input logic [4:0] b,
                                  input logic [NUM_FWD-1:0] en,
                                  input logic [NUM_FWD*5-1:0] wa);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (en[k] && (wa[5*k +: 5] != 5'd0) && ((wa[5*k +: 5] == a) || (wa[5*k +: 5] == b)))
        hit = 1'b1;
    end
    return hit;
  endfunction

`ifdef ID_FWD_EN
  // Youngest matching source wins; r0 is hardwired to zero
  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rfd,
                                          input logic [NUM_FWD-1:0] we,
                                          input logic [NUM_FWD*5-1:0] wa,
                                          input logic [NUM_FWD*32-1:0] wd);
    logic [31:0] v;
    logic        found;
    v     = rfd;
    found = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!found && we[k] && (wa[5*k +: 5] == r)) begin
        v     = wd[32*k +: 32];
        found = 1'b1;
      end
    end
    if (r == 5'd0) v = '0;
    return v;
  endfunction

  assign stall_src = bus.fwd_we & bus.fwd_is_load;
  assign src1      = resolve(rs, bus.rf_rdata1, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata);
  assign src2      = resolve(rt, bus.rf_rdata2, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata);
`else
  logic unused_fwd;

  assign stall_src  = bus.fwd_we;
  assign src1       = (rs == 5'd0) ? 32'd0 : bus.rf_rdata1;
  assign src2       = (rt == 5'd0) ? 32'd0 : bus.rf_rdata2;
  assign unused_fwd = ^{bus.fwd_is_load, bus.fwd_wdata};
`endif

  // Select the instruction word: fresh SRAM data or the held copy
  always_comb begin
    cur_inst = 32'd0;
    case (state)
      LIVE:    cur_inst = bus.inst_rdata;
      HOLD:    cur_inst = hold_r;
      default: cur_inst = 32'd0;
    endcase
  end

  assign rs       = cur_inst[25:21];
  assign rt       = cur_inst[20:16];
  assign op       = cur_inst[31:26];
  assign load_use = hazard(rs, rt, stall_src, bus.fwd_waddr);
  assign issue    = !rst && (state != IDLE) && !load_use && bus.ex_ready;
  assign accept   = bus.if_valid && bus.id_ready;
  assign pc4      = pc_r + 32'd4;

  // Branch / jump resolution on the resolved operands
  always_comb begin
    taken  = 1'b0;
    target = 32'd0;
    case (op)
      6'h04: begin
        taken  = (src1 == src2);
        target = pc4 + {{14{cur_inst[15]}}, cur_inst[15:0], 2'b00};
      end
      6'h05: begin
        taken  = (src1 != src2);
        target = pc4 + {{14{cur_inst[15]}}, cur_inst[15:0], 2'b00};
      end
      6'h02, 6'h03: begin
        taken  = 1'b1;
        target = {pc4[31:28], cur_inst[25:0], 2'b00};
      end
      6'h00: begin
        taken  = (cur_inst[5:0] == 6'h08);
        target = src1;
      end
      default: begin
        taken  = 1'b0;
        target = 32'd0;
      end
    endcase
  end

  assign bus.id_ready      = (state == IDLE) || issue;
  assign bus.id_valid      = issue;
  assign bus.id_pc         = issue ? pc_r : 32'd0;
  assign bus.id_inst       = issue ? cur_inst : 32'd0;
  assign bus.id_src1       = issue ? src1 : 32'd0;
  assign bus.id_src2       = issue ? src2 : 32'd0;
  assign bus.br_taken      = issue && taken;
  assign bus.br_target     = (issue && taken) ? target : 32'd0;
  assign bus.rf_raddr1     = rs;
  assign bus.rf_raddr2     = rt;
  assign bus.interlock_cnt = cnt_r;

  // Slot state, PC/hold capture and saturating interlock counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_r   <= 32'd0;
      hold_r <= 32'd0;
      cnt_r  <= '0;
    end else begin
      if (accept) pc_r <= bus.if_pc;
      case (state)
        IDLE: if (accept) state <= LIVE;
        LIVE: begin
          if (issue) begin
            state <= accept ? LIVE : IDLE;
          end else begin
            state  <= HOLD;
            hold_r <= bus.inst_rdata;
          end
        end
        HOLD: if (issue) state <= accept ? LIVE : IDLE;
        default: state <= IDLE;
      endcase
      if ((state != IDLE) && load_use && (cnt_r != '1))
        cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: directed scenarios followed by random traffic,
// all checked every cycle against a slot-level reference model.
module tb_id_fwd_stage;
  localparam int unsigned NUM_FWD = 3;
  localparam int unsigned CNT_W   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_fwd_stage_if #(.NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus ();
  id_fwd_stage #(.NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file and forwarding sources as plain arrays
  logic [31:0] rf  [32];
  logic        fwe [NUM_FWD];
  logic        fld [NUM_FWD];
  logic [4:0]  fwa [NUM_FWD];
  logic [31:0] fwd [NUM_FWD];

  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      bus.fwd_we[k]            = fwe[k];
      bus.fwd_is_load[k]       = fld[k];
      bus.fwd_waddr[5*k +: 5]  = fwa[k];
      bus.fwd_wdata[32*k +: 32] = fwd[k];
    end
  end
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: one instruction slot with optional captured word
  logic        m_full, m_known;
  logic [31:0] m_pc, m_word, m_cnt, pending;
  logic        e_lu, e_issue, e_ready, e_bt;
  logic [31:0] e_pc, e_inst, e_src1, e_src2, e_btgt;
  logic [4:0]  e_ra1, e_ra2;

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen_inst();
    case ($urandom_range(0, 6))
      0:       return enc_r(rreg(), rreg(), rreg(), 6'h21);
      1:       return enc_i(6'h0d, rreg(), rreg(), 16'($urandom));
      2:       return enc_i(6'h04, rreg(), rreg(), 16'($urandom));
      3:       return enc_i(6'h05, rreg(), rreg(), 16'($urandom));
      4:       return {6'h02, 26'($urandom)};
      5:       return {6'h03, 26'($urandom)};
      default: return enc_r(rreg(), 5'd0, 5'd0, 6'h08);
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_FWD_EN
    for (int k = 0; k < NUM_FWD; k++)
      if (fwe[k] && fwa[k] == r) return fwd[k];
`endif
    return rf[r];
  endfunction

  task automatic model_eval();
    logic [31:0] cur, pc4, tgt;
    logic [4:0]  s, t;
    logic        tk, blocks;
    int          off;
    cur = m_full ? (m_known ? m_word : bus.inst_rdata) : 32'd0;
    s = cur[25:21];
    t = cur[20:16];
    e_lu = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      blocks = fwe[k];
`ifdef ID_FWD_EN
      blocks = fwe[k] && fld[k];
`endif
      if (blocks && fwa[k] != 5'd0 && (fwa[k] == s || fwa[k] == t)) e_lu = 1'b1;
    end
    e_issue = !rst && m_full && !e_lu && bus.ex_ready;
    e_ready = !m_full || e_issue;
    pc4 = m_pc + 32'd4;
    off = int'($signed(cur[15:0])) * 4;
    tk = 1'b0;
    tgt = 32'd0;
    if (cur[31:26] == 6'h04) begin tk = (operand(s) == operand(t)); tgt = pc4 + 32'(off); end
    else if (cur[31:26] == 6'h05) begin tk = (operand(s) != operand(t)); tgt = pc4 + 32'(off); end
    else if (cur[31:26] == 6'h02 || cur[31:26] == 6'h03) begin
      tk = 1'b1;
      tgt = (pc4 & 32'hF000_0000) | (32'(cur[25:0]) * 32'd4);
    end else if (cur[31:26] == 6'h00 && cur[5:0] == 6'h08) begin tk = 1'b1; tgt = operand(s); end
    e_bt   = e_issue && tk;
    e_btgt = e_bt ? tgt : 32'd0;
    e_pc   = e_issue ? m_pc : 32'd0;
    e_inst = e_issue ? cur : 32'd0;
    e_src1 = e_issue ? operand(s) : 32'd0;
    e_src2 = e_issue ? operand(t) : 32'd0;
    e_ra1  = s;
    e_ra2  = t;
  endtask

  task automatic model_commit();
    logic acc;
    if (rst) begin
      m_full = 1'b0; m_known = 1'b0; m_pc = 32'd0; m_word = 32'd0; m_cnt = 32'd0;
    end else begin
      if (m_full && e_lu) m_cnt = m_cnt + 32'd1;
      acc = bus.if_valid && e_ready;
      if (e_issue) m_full = 1'b0;
      else if (m_full && !m_known) begin m_known = 1'b1; m_word = bus.inst_rdata; end
      if (acc) begin
        m_full = 1'b1; m_known = 1'b0; m_pc = bus.if_pc; pending = gen_inst();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("id_ready", 64'(bus.id_ready), 64'(e_ready));
    chk("id_valid", 64'(bus.id_valid), 64'(e_issue));
    chk("id_pc", 64'(bus.id_pc), 64'(e_pc));
    chk("id_inst", 64'(bus.id_inst), 64'(e_inst));
    chk("id_src1", 64'(bus.id_src1), 64'(e_src1));
    chk("id_src2", 64'(bus.id_src2), 64'(e_src2));
    chk("br_taken", 64'(bus.br_taken), 64'(e_bt));
    chk("br_target", 64'(bus.br_target), 64'(e_btgt));
    chk("rf_raddr1", 64'(bus.rf_raddr1), 64'(e_ra1));
    chk("rf_raddr2", 64'(bus.rf_raddr2), 64'(e_ra2));
    chk("interlock_cnt", 64'(bus.interlock_cnt), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_fwd();
    for (int k = 0; k < NUM_FWD; k++) begin
      fwe[k] = 1'b0; fld[k] = 1'b0; fwa[k] = 5'd0; fwd[k] = 32'd0;
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] w);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    settle();
    tick();
    bus.if_valid   = 1'b0;
    bus.inst_rdata = w;
  endtask

  initial begin
    logic [31:0] w;
    m_full = 1'b0; m_known = 1'b0; m_pc = 32'd0; m_word = 32'd0; m_cnt = 32'd0; pending = 32'd0;
    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_pc = 32'd0; bus.inst_rdata = 32'd0; bus.ex_ready = 1'b1;
    clear_fwd();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset_ready", 64'(bus.id_ready), 64'd1);
    chk("reset_valid", 64'(bus.id_valid), 64'd0);
    chk("reset_cnt", 64'(bus.interlock_cnt), 64'd0);
    tick();

    // Back-to-back independent instructions
    bus.if_valid = 1'b1; bus.if_pc = 32'h40;
    settle(); tick();
    bus.inst_rdata = enc_i(6'h0d, 5'd3, 5'd2, 16'h1234); bus.if_pc = 32'h44;
    settle(); chk("b2b_issue0", 64'(bus.id_valid), 64'd1); tick();
    bus.if_valid = 1'b0; bus.inst_rdata = enc_r(5'd6, 5'd7, 5'd4, 6'h21);
    settle();
    chk("b2b_issue1", 64'(bus.id_valid), 64'd1);
    chk("b2b_pc1", 64'(bus.id_pc), 64'h44);
    chk("b2b_cnt", 64'(bus.interlock_cnt), 64'd0);
    tick();
    bus.inst_rdata = 32'd0;
    settle(); tick();

    // Load-use: two bubble cycles, then issue with the original word
    w = enc_r(5'd4, 5'd8, 5'd9, 6'h21);
    fetch(32'h200, w);
    fwe[0] = 1'b1; fld[0] = 1'b1; fwa[0] = 5'd8; fwd[0] = $urandom;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("lu_valid", 64'(bus.id_valid), 64'd0);
      chk("lu_ready", 64'(bus.id_ready), 64'd0);
      tick();
      bus.inst_rdata = 32'hDEAD_BEEF;
    end
    clear_fwd();
    settle();
    chk("lu_issue", 64'(bus.id_valid), 64'd1);
    chk("lu_inst", 64'(bus.id_inst), 64'(w));
    chk("lu_cnt", 64'(bus.interlock_cnt), 64'd2);
    tick();

    // Forwarding priority on r5
    rf[5] = 32'h55;
    fetch(32'h300, enc_r(5'd5, 5'd0, 5'd1, 6'h21));
    fwe[0] = 1'b1; fwa[0] = 5'd5; fwd[0] = 32'h11;
    fwe[2] = 1'b1; fwa[2] = 5'd5; fwd[2] = 32'h22;
    settle();
`ifdef ID_FWD_EN
    chk("fwd_valid", 64'(bus.id_valid), 64'd1);
    chk("fwd_src1", 64'(bus.id_src1), 64'h11);
    chk("fwd_src2", 64'(bus.id_src2), 64'd0);
`else
    chk("nofwd_stall", 64'(bus.id_valid), 64'd0);
`endif
    tick();
    clear_fwd();
    settle(); tick();

    // Backpressure with SRAM data changing under a held instruction
    w = enc_i(6'h0d, 5'd1, 5'd3, 16'hA5A5);
    fetch(32'h400, w);
    bus.ex_ready = 1'b0;
    settle(); chk("bp_stall", 64'(bus.id_valid), 64'd0); tick();
    bus.inst_rdata = 32'h1111_2222; settle(); tick();
    bus.inst_rdata = 32'h3333_4444; settle(); tick();
    bus.ex_ready = 1'b1; bus.inst_rdata = 32'h5555_6666;
    settle();
    chk("bp_inst", 64'(bus.id_inst), 64'(w));
    tick();

    // Branches and jr
    rf[1] = 32'd7; rf[2] = 32'd7;
    fetch(32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'h0004));
    settle();
    chk("beq_taken", 64'(bus.br_taken), 64'd1);
    chk("beq_target", 64'(bus.br_target), 64'h114);
    tick();
    rf[2] = 32'd9;
    fetch(32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'h0004));
    settle(); chk("beq_not_taken", 64'(bus.br_taken), 64'd0); tick();
    rf[31] = 32'hBFC0_0010;
    fetch(32'h500, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    settle(); chk("jr_target", 64'(bus.br_target), 64'hBFC0_0010); tick();

    // Reset while holding an instruction
    fetch(32'h600, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
    bus.ex_ready = 1'b0;
    settle(); tick();
    bus.inst_rdata = 32'h0BAD_0BAD;
    settle(); tick();
    bus.ex_ready = 1'b1; rst = 1'b1;
    settle(); chk("rst_hold_no_issue", 64'(bus.id_valid), 64'd0); tick();
    rst = 1'b0;
    settle();
    chk("post_rst_valid", 64'(bus.id_valid), 64'd0);
    chk("post_rst_ready", 64'(bus.id_ready), 64'd1);
    chk("post_rst_cnt", 64'(bus.interlock_cnt), 64'd0);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      bus.if_valid = ($urandom_range(0, 9) < 7);
      bus.if_pc = {$urandom, 2'b00} >> 2 << 2;
      bus.ex_ready = ($urandom_range(0, 9) < 8);
      bus.inst_rdata = (m_full && !m_known) ? pending : $urandom;
      for (int k = 0; k < NUM_FWD; k++) begin
        fwe[k] = $urandom_range(0, 1) == 1;
        fld[k] = $urandom_range(0, 3) == 0;
        fwa[k] = 5'($urandom_range(0, 7));
        fwd[k] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
